// File: rtl/division_arbiter.sv
// Round-robin sequencer sharing one iterative divider; accept->engine strobe 1 cycle, engine edge->rsp 1 cycle.
// One transaction in flight; other requesters keep req_valid high and wait (never dropped).
module division_arbiter #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [10*N_REQ-1:0]   req_a,
   input  logic [3*N_REQ-1:0]    req_b,
   output logic [N_REQ-1:0]      req_ready,
   output logic                  eng_in_valid,
   output logic [9:0]            eng_in_data_1,
   output logic [2:0]            eng_in_data_2,
   input  logic                  eng_out_valid,
   input  logic [19:0]           eng_out_data,
   output logic                  rsp_valid,
   output logic [2:0]            rsp_id,
   output logic [19:0]           rsp_data,
   output logic                  rsp_err,
   output logic                  busy
);
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

   state_t            state, next_state;
   logic [2:0]        last;
   logic [2:0]        cur_id;
   logic [2:0]        grant_id;
   logic              grant_any;
   logic              accept;
   logic              b_zero;
   logic              eng_edge;
   logic              timed_out;
   logic              ov_q;
   logic [CNT_W-1:0]  wait_cnt;
   logic [9:0]        sel_a;
   logic [2:0]        sel_b;
   logic [3:0]        probe;
   logic [N_REQ-1:0]  rv_rot;

   // Search starts just after the last winner and wraps, giving round-robin fairness.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      probe     = '0;
      rv_rot    = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         probe = {1'b0, last} + 4'(k);
         if (probe >= 4'(N_REQ)) probe = probe - 4'(N_REQ);
         rv_rot = req_valid >> probe;
         if (!grant_any && rv_rot[0]) begin
            grant_any = 1'b1;
            grant_id  = probe[2:0];
         end
      end
   end

   always_comb begin
      sel_a     = 10'(req_a >> (10 * grant_id));
      sel_b     = 3'(req_b >> (3 * grant_id));
      b_zero    = (sel_b == 3'd0);
      accept    = (state == IDLE) && grant_any && !rst;
      req_ready = accept ? (N_REQ'(1) << grant_id) : '0;
      eng_edge  = eng_out_valid && !ov_q;
      timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (accept) next_state = b_zero ? RESP : ISSUE;
         ISSUE: next_state = WAIT;
         WAIT:  if (eng_edge || timed_out) next_state = RESP;
         RESP:  next_state = DRAIN;
         DRAIN: if (!eng_out_valid) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Outputs are registered from next_state so each lines up with its state cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         last          <= 3'(N_REQ - 1);
         cur_id        <= '0;
         ov_q          <= 1'b0;
         wait_cnt      <= '0;
         busy          <= 1'b0;
         eng_in_valid  <= 1'b0;
         eng_in_data_1 <= '0;
         eng_in_data_2 <= '0;
         rsp_valid     <= 1'b0;
         rsp_id        <= '0;
         rsp_data      <= '0;
         rsp_err       <= 1'b0;
      end else begin
         ov_q         <= eng_out_valid;
         busy         <= (next_state != IDLE);
         eng_in_valid <= (next_state == ISSUE);
         rsp_valid    <= (next_state == RESP);
         wait_cnt     <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
         if (accept) begin
            last   <= grant_id;
            cur_id <= grant_id;
            if (b_zero) begin
               rsp_id   <= grant_id;
               rsp_data <= '0;
               rsp_err  <= 1'b1;
            end else begin
               eng_in_data_1 <= sel_a;
               eng_in_data_2 <= sel_b;
            end
         end
         if (state == WAIT) begin
            if (eng_edge) begin
               rsp_id   <= cur_id;
               rsp_data <= eng_out_data;
               rsp_err  <= 1'b0;
            end else if (timed_out) begin
               rsp_id   <= cur_id;
               rsp_data <= '0;
               rsp_err  <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_division_arbiter.sv
// Directed bench for division_arbiter: arbitration order, latencies, error paths, drain and reset.
module tb_division_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [39:0] req_a;
   logic [11:0] req_b;
   logic [3:0]  req_ready;
   logic        eng_in_valid;
   logic [9:0]  eng_in_data_1;
   logic [2:0]  eng_in_data_2;
   logic        eng_out_valid = 1'b0;
   logic [19:0] eng_out_data = '0;
   logic        rsp_valid;
   logic [2:0]  rsp_id;
   logic [19:0] rsp_data;
   logic        rsp_err;
   logic        busy;

   logic [9:0]  a_arr [4] = '{default: '0};
   logic [2:0]  b_arr [4] = '{default: '0};
   assign req_a = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
   assign req_b = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

   int checks = 0;
   int failures = 0;
   int ein_cnt = 0;
   int rsp_cnt = 0;
   bit eng_en = 1'b1;
   int eng_delay = 3;
   int eng_hold = 1;

   division_arbiter #(.N_REQ(4), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .eng_in_valid(eng_in_valid), .eng_in_data_1(eng_in_data_1),
      .eng_in_data_2(eng_in_data_2), .eng_out_valid(eng_out_valid), .eng_out_data(eng_out_data),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rsp_valid) rsp_cnt++;
      if (eng_in_valid) ein_cnt++;
   end

   // Engine: quotient appears eng_delay cycles after the input strobe, held eng_hold cycles.
   always begin : engine
      logic [19:0] q;
      @(posedge clk); #1;
      if (eng_in_valid && eng_en) begin
         q = 20'(eng_in_data_1) / 20'(eng_in_data_2);
         repeat (eng_delay) begin @(posedge clk); #1; end
         eng_out_valid = 1'b1;
         eng_out_data  = q;
         repeat (eng_hold) begin @(posedge clk); #1; end
         eng_out_valid = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_rsp(input int budget, output int n);
      n = 0;
      while (!rsp_valid && n < budget) begin tick(); n++; end
   endtask

   task automatic wait_ready(input int budget, output int n);
      n = 0;
      while (req_ready == 4'b0 && n < budget) begin tick(); n++; end
   endtask

   task automatic wait_idle(input int budget, output int n);
      n = 0;
      while (busy && n < budget) begin tick(); n++; end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '0;
      tick(); tick();
      rst = 1'b0; #1;
      checks++;
      if ({eng_in_valid, eng_in_data_1, eng_in_data_2, rsp_valid, rsp_id, rsp_data, rsp_err} !== 38'b0) begin
         failures++; $display("FAIL reset_outputs got=%0h exp=0", {eng_in_valid, eng_in_data_1, eng_in_data_2, rsp_valid, rsp_id, rsp_data, rsp_err});
      end
      checks++;
      if (busy !== 1'b0 || req_ready !== 4'b0) begin
         failures++; $display("FAIL reset_busy_ready got busy=%b ready=%b exp 0/0000", busy, req_ready);
      end
   endtask

   task automatic test_single();
      int n, e0, r0;
      eng_en = 1'b1; eng_delay = 20; eng_hold = 1;
      e0 = ein_cnt; r0 = rsp_cnt;
      a_arr[0] = 10'd10; b_arr[0] = 3'd2; req_valid = 4'b0001; #1;
      checks++;
      if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
      tick(); req_valid = '0;
      checks++;
      if (eng_in_valid !== 1'b1 || eng_in_data_1 !== 10'd10 || eng_in_data_2 !== 3'd2 || busy !== 1'b1) begin
         failures++; $display("FAIL single_issue got v=%b a=%0d b=%0d busy=%b exp 1/10/2/1", eng_in_valid, eng_in_data_1, eng_in_data_2, busy);
      end
      tick();
      checks++;
      if (eng_in_valid !== 1'b0) begin failures++; $display("FAIL single_issue_len got=%b exp=0", eng_in_valid); end
      wait_rsp(100, n);
      checks++;
      if (n != 20 || rsp_id !== 3'd0 || rsp_data !== 20'h00005 || rsp_err !== 1'b0) begin
         failures++; $display("FAIL single_rsp got n=%0d id=%0d data=%0h err=%b exp 20/0/5/0", n, rsp_id, rsp_data, rsp_err);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== 20'h00005) begin
         failures++; $display("FAIL single_rsp_hold got v=%b data=%0h exp 0/5", rsp_valid, rsp_data);
      end
      wait_idle(20, n);
      checks++;
      if (n != 1 || ein_cnt - e0 != 1 || rsp_cnt - r0 != 1) begin
         failures++; $display("FAIL single_drain got n=%0d ein=%0d rsp=%0d exp 1/1/1", n, ein_cnt - e0, rsp_cnt - r0);
      end
   endtask

   task automatic test_round_robin();
      int n;
      int exp_id [5] = '{0, 1, 2, 3, 0};
      logic [19:0] exp_q [5] = '{20'd33, 20'd146, 20'd125, 20'd15, 20'd33};
      rst = 1'b1; tick(); rst = 1'b0;
      eng_en = 1'b1; eng_delay = 3; eng_hold = 1;
      a_arr[0] = 10'd100;  b_arr[0] = 3'd3;
      a_arr[1] = 10'd1023; b_arr[1] = 3'd7;
      a_arr[2] = 10'd500;  b_arr[2] = 3'd4;
      a_arr[3] = 10'd77;   b_arr[3] = 3'd5;
      req_valid = 4'b1111; #1;
      for (int g = 0; g < 5; g++) begin
         wait_ready(50, n);
         checks++;
         if (req_ready !== (4'b0001 << exp_id[g])) begin
            failures++; $display("FAIL rr_grant%0d got=%b exp_id=%0d", g, req_ready, exp_id[g]);
         end
         tick();
         if (g == 4) req_valid = '0;
         wait_rsp(50, n);
         checks++;
         if (!rsp_valid || rsp_id !== 3'(exp_id[g]) || rsp_data !== exp_q[g] || rsp_err !== 1'b0) begin
            failures++; $display("FAIL rr_rsp%0d got v=%b id=%0d data=%0d err=%b exp id=%0d data=%0d", g, rsp_valid, rsp_id, rsp_data, rsp_err, exp_id[g], exp_q[g]);
         end
      end
      wait_idle(20, n);
   endtask

   task automatic test_div_zero();
      int n, e0;
      e0 = ein_cnt;
      a_arr[2] = 10'd123; b_arr[2] = 3'd0; req_valid = 4'b0100; #1;
      checks++;
      if (req_ready !== 4'b0100) begin failures++; $display("FAIL dz_ready got=%b exp=0100", req_ready); end
      tick(); req_valid = '0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 20'h0 || rsp_id !== 3'd2 || eng_in_valid !== 1'b0) begin
         failures++; $display("FAIL dz_rsp got v=%b err=%b data=%0h id=%0d ein=%b exp 1/1/0/2/0", rsp_valid, rsp_err, rsp_data, rsp_id, eng_in_valid);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL dz_drain got v=%b busy=%b exp 0/1", rsp_valid, busy); end
      tick();
      checks++;
      if (busy !== 1'b0 || ein_cnt != e0) begin failures++; $display("FAIL dz_idle got busy=%b ein=%0d exp 0/0", busy, ein_cnt - e0); end
      wait_idle(10, n);
   endtask

   task automatic test_timeout();
      int n;
      eng_en = 1'b0;
      a_arr[1] = 10'd50; b_arr[1] = 3'd5; req_valid = 4'b0010; #1;
      checks++;
      if (req_ready !== 4'b0010) begin failures++; $display("FAIL to_ready got=%b exp=0010", req_ready); end
      tick(); req_valid = '0;
      wait_rsp(200, n);
      checks++;
      if (n != 65 || rsp_err !== 1'b1 || rsp_data !== 20'h0 || rsp_id !== 3'd1) begin
         failures++; $display("FAIL to_rsp got n=%0d err=%b data=%0h id=%0d exp 65/1/0/1", n, rsp_err, rsp_data, rsp_id);
      end
      eng_en = 1'b1; eng_delay = 2; eng_hold = 1;
      a_arr[3] = 10'd60; b_arr[3] = 3'd6; req_valid = 4'b1000; #1;
      wait_ready(20, n);
      checks++;
      if (n != 2 || req_ready !== 4'b1000) begin failures++; $display("FAIL to_next_accept got n=%0d ready=%b exp 2/1000", n, req_ready); end
      tick(); req_valid = '0;
      wait_rsp(50, n);
      checks++;
      if (rsp_data !== 20'd10 || rsp_id !== 3'd3 || rsp_err !== 1'b0) begin
         failures++; $display("FAIL to_next_rsp got data=%0d id=%0d err=%b exp 10/3/0", rsp_data, rsp_id, rsp_err);
      end
      wait_idle(20, n);
   endtask

   task automatic test_hold_drain();
      int n, r0;
      eng_en = 1'b1; eng_delay = 4; eng_hold = 3;
      r0 = rsp_cnt;
      a_arr[0] = 10'd9; b_arr[0] = 3'd3; req_valid = 4'b0001; #1;
      checks++;
      if (req_ready !== 4'b0001) begin failures++; $display("FAIL hold_ready got=%b exp=0001", req_ready); end
      tick();
      a_arr[1] = 10'd8; b_arr[1] = 3'd2; req_valid = 4'b0010;
      wait_rsp(50, n);
      checks++;
      if (n != 5 || rsp_id !== 3'd0 || rsp_data !== 20'd3) begin
         failures++; $display("FAIL hold_rsp got n=%0d id=%0d data=%0d exp 5/0/3", n, rsp_id, rsp_data);
      end
      wait_ready(20, n);
      checks++;
      if (n != 3 || req_ready !== 4'b0010 || rsp_cnt - r0 != 1) begin
         failures++; $display("FAIL hold_drain got n=%0d ready=%b rsps=%0d exp 3/0010/1", n, req_ready, rsp_cnt - r0);
      end
      tick(); req_valid = '0;
      wait_rsp(50, n);
      checks++;
      if (rsp_id !== 3'd1 || rsp_data !== 20'd4) begin failures++; $display("FAIL hold_rsp2 got id=%0d data=%0d exp 1/4", rsp_id, rsp_data); end
      wait_idle(20, n);
      checks++;
      if (rsp_cnt - r0 != 2) begin failures++; $display("FAIL hold_count got=%0d exp=2", rsp_cnt - r0); end
   endtask

   task automatic test_reset_in_wait();
      int n, r0;
      eng_en = 1'b0;
      a_arr[3] = 10'd40; b_arr[3] = 3'd4; req_valid = 4'b1000; #1;
      tick(); req_valid = '0;
      tick(); tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({eng_in_valid, eng_in_data_1, eng_in_data_2, rsp_valid, rsp_id, rsp_data, rsp_err, busy} !== 39'b0) begin
         failures++; $display("FAIL rstwait_outputs got=%0h exp=0", {eng_in_valid, eng_in_data_1, eng_in_data_2, rsp_valid, rsp_id, rsp_data, rsp_err, busy});
      end
      rst = 1'b0;
      r0 = rsp_cnt;
      repeat (70) tick();
      checks++;
      if (rsp_cnt != r0 || busy !== 1'b0) begin failures++; $display("FAIL rstwait_no_rsp got rsps=%0d busy=%b exp 0/0", rsp_cnt - r0, busy); end
      eng_en = 1'b1; eng_delay = 2; eng_hold = 1;
      a_arr[0] = 10'd200; b_arr[0] = 3'd7; req_valid = 4'b1111; #1;
      checks++;
      if (req_ready !== 4'b0001) begin failures++; $display("FAIL rstwait_grant got=%b exp=0001", req_ready); end
      tick(); req_valid = '0;
      wait_rsp(50, n);
      checks++;
      if (rsp_id !== 3'd0 || rsp_data !== 20'd28 || rsp_err !== 1'b0) begin
         failures++; $display("FAIL rstwait_rsp got id=%0d data=%0d err=%b exp 0/28/0", rsp_id, rsp_data, rsp_err);
      end
      wait_idle(20, n);
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_div_zero();
      test_timeout();
      test_hold_drain();
      test_reset_in_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/division_arbiter.md
# division_arbiter

Round-robin arbiter and sequencer that shares one iterative division engine among up to N_REQ requesters. It accepts a request (10-bit dividend, 3-bit divisor) from one requester at a time and drives the engine's level-sensitive input protocol. It then captures the engine's 20-bit quotient and returns it, tagged with the requester index, on a single shared response channel. It sits between the client blocks and the division engine and also handles divide-by-zero and engine timeout.

## Interface
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT, 64, max cycles in WAIT before error response (≥4)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request; held with data stable until its req_ready
- req_a  in  10*N_REQ  dividends, requester i at [10i+9:10i]
- req_b  in  3*N_REQ  divisors, requester i at [3i+2:3i]
- req_ready  out  N_REQ  one-hot acceptance pulse
- eng_in_valid  out  1  engine input valid
- eng_in_data_1  out  10  engine dividend
- eng_in_data_2  out  3  engine divisor
- eng_out_valid  in  1  engine result valid (may stay high several cycles)
- eng_out_data  in  20  engine quotient
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  3  requester index of response
- rsp_data  out  20  quotient (0 on error)
- rsp_err  out  1  1 = divide-by-zero or timeout
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN; reset → IDLE.
- Priority pointer `last` (reset N_REQ-1). In IDLE, grant g = first i with req_valid[i], searching from last+1 upward and wrapping.
- IDLE with any req_valid: req_ready[g]=1 combinationally in that cycle; latch a, b, g into cur_a, cur_b, cur_id; last←g.
  - b==0 → RESP with err=1, engine untouched.
  - otherwise → ISSUE.
- ISSUE (exactly 1 cycle): eng_in_valid=1, eng_in_data_1=cur_a, eng_in_data_2=cur_b; → WAIT.
- WAIT: eng_in_valid=0. A rising edge of eng_out_valid (high now, low the previous cycle) captures eng_out_data and goes to RESP with err=0. Timeout counter starts at 0 on WAIT entry; when it reaches TIMEOUT-1 without an edge → RESP with err=1, data 0.
- RESP (1 cycle): rsp_valid=1 with rsp_id=cur_id, rsp_data, rsp_err → DRAIN.
- DRAIN: stay until eng_out_valid==0, then → IDLE. A divide-by-zero response also passes through DRAIN and normally exits next cycle.
- eng_in_data_* hold the last issued values outside ISSUE. rsp_* hold their values when rsp_valid=0.
- eng_out_valid activity in IDLE/ISSUE is ignored; the edge detector register still tracks it.
- req_valid changes outside IDLE have no effect. Requests are never dropped; they wait.
- Only one transaction is outstanding at any time.

## Timing
- Reset values: req_ready=0, eng_in_valid=0, eng_in_data_1=0, eng_in_data_2=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0, last=N_REQ-1, timeout counter 0, edge-detect register 0.
- Accept at cycle t → eng_in_valid high at t+1 only.
- Engine edge first seen in cycle w → rsp_valid at w+1.
- Divide-by-zero accept at t → rsp_valid at t+1, err=1.
- Timeout: WAIT entered at t+2 → rsp_valid at t+2+TIMEOUT.
- Back-to-back: earliest next acceptance is the cycle after DRAIN exits.
- rst asserted in any state → next cycle all outputs at reset values, state IDLE. Any in-flight result is discarded and the engine is not notified.
- All outputs except req_ready are registered. req_ready is combinational from state, req_valid and last.

## Test plan
- Reset then req_valid=0001, a=10, b=2; engine model raises out_valid 20 cycles after input, data 0x00005 → req_ready=0001 at accept, one eng_in_valid pulse, rsp_valid with id=0, data=0x00005, err=0; busy low after DRAIN.
- req_valid=1111 held continuously, distinct data per requester → grants in order 0,1,2,3,0; each rsp_id matches the grant and each result matches its own operands.
- Requester 2 with b=0 → rsp_valid one cycle after accept, err=1, data=0, id=2, eng_in_valid never asserted.
- Engine never responds, TIMEOUT=64 → rsp_err=1 exactly 64 cycles after WAIT entry; next request accepted once eng_out_valid=0.
- Engine holds out_valid high for 3 cycles → exactly one rsp_valid. DRAIN blocks a pending request until out_valid falls.
- rst pulsed during WAIT → all outputs at reset values next cycle, no response emitted, and the next grant goes to requester 0.
